// File: rtl/tree_packet_arb_sched.sv
// Credit-based round-robin scheduler: tags each packet's ctl with a destination core id.
// One-register output stage; per-core credit counters refilled by single-cycle done pulses.
module tree_packet_arb_sched #(
   parameter int DAT_BYTS     = 8,
   parameter int DAT_BITS     = DAT_BYTS * 8,
   parameter int CTL_BITS     = 8,
   parameter int NUM_OUT      = 8,
   parameter int LOG2_NUM_OUT = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
   parameter int OVR_WRT_BIT  = CTL_BITS - LOG2_NUM_OUT,
   parameter int CREDITS      = 4,
   parameter int CRED_BITS    = $clog2(CREDITS + 1),
   localparam int MOD_BITS    = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_axi_val,
   output logic                i_axi_rdy,
   input  logic [DAT_BITS-1:0] i_axi_dat,
   input  logic [CTL_BITS-1:0] i_axi_ctl,
   input  logic                i_axi_sop,
   input  logic                i_axi_eop,
   input  logic                i_axi_err,
   input  logic [MOD_BITS-1:0] i_axi_mod,
   output logic                o_axi_val,
   input  logic                o_axi_rdy,
   output logic [DAT_BITS-1:0] o_axi_dat,
   output logic [CTL_BITS-1:0] o_axi_ctl,
   output logic                o_axi_sop,
   output logic                o_axi_eop,
   output logic                o_axi_err,
   output logic [MOD_BITS-1:0] o_axi_mod,
   input  logic [NUM_OUT-1:0]  i_done,
   output logic [NUM_OUT-1:0]  o_cred_ok,
   output logic                o_idle,
   output logic [1:0]          o_err
);

   localparam int unsigned N_OUT = NUM_OUT;
   localparam logic [CRED_BITS-1:0] CRED_FULL = CRED_BITS'(CREDITS);

   typedef enum logic {IDLE, PKT} state_t;

   state_t                  state;
   logic [LOG2_NUM_OUT-1:0] rr_ptr;
   logic [LOG2_NUM_OUT-1:0] lock_id;
   logic [CRED_BITS-1:0]    credit [NUM_OUT];
   logic                    err_done;
   logic                    err_sop;

   logic [NUM_OUT-1:0]      cred_nz;
   logic [NUM_OUT-1:0]      cred_full;
   logic [NUM_OUT-1:0]      take_vec;
   logic [LOG2_NUM_OUT-1:0] sel;
   logic [LOG2_NUM_OUT-1:0] idx;
   logic [LOG2_NUM_OUT-1:0] tag_id;
   logic [CTL_BITS-1:0]     ctl_tag;
   logic                    any_cred;
   logic                    gate;
   logic                    accept;
   logic                    take;
   logic                    fwd;

   always_comb begin
      for (int unsigned h = 0; h < N_OUT; h++) begin
         cred_nz[h]   = (credit[h] != '0);
         cred_full[h] = (credit[h] == CRED_FULL);
      end
   end

   // Scan offsets from farthest to nearest so the nearest credited core wins.
   always_comb begin
      sel      = rr_ptr;
      idx      = '0;
      any_cred = 1'b0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         idx = LOG2_NUM_OUT'((32'(rr_ptr) + N_OUT - 1 - k) % N_OUT);
         if (cred_nz[idx]) begin
            sel      = idx;
            any_cred = 1'b1;
         end
      end
   end

   assign gate      = (state == PKT) ? 1'b1 : any_cred;
   assign i_axi_rdy = (o_axi_rdy | ~o_axi_val) & gate;
   assign accept    = i_axi_val & i_axi_rdy;
   assign take      = accept & (state == IDLE) & i_axi_sop;
   assign fwd       = accept & ((state == PKT) | i_axi_sop);
   assign tag_id    = (state == IDLE) ? sel : lock_id;

   always_comb begin
      ctl_tag = i_axi_ctl;
      ctl_tag[OVR_WRT_BIT +: LOG2_NUM_OUT] = tag_id;
   end

   always_comb begin
      take_vec = '0;
      if (take) take_vec[sel] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         lock_id <= '0;
         err_sop <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (i_axi_sop) begin
                     rr_ptr  <= LOG2_NUM_OUT'((32'(sel) + 1) % N_OUT);
                     lock_id <= sel;
                     if (!i_axi_eop) state <= PKT;
                  end else begin
                     err_sop <= 1'b1;
                  end
               end
            end
            PKT: begin
               if (accept && i_axi_eop) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A take and a done on the same core cancel, even when that core is full.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int unsigned h = 0; h < N_OUT; h++) credit[h] <= CRED_FULL;
         err_done <= 1'b0;
      end else begin
         for (int unsigned h = 0; h < N_OUT; h++) begin
            if (take_vec[h] && !i_done[h])
               credit[h] <= credit[h] - CRED_BITS'(1);
            else if (!take_vec[h] && i_done[h] && !cred_full[h])
               credit[h] <= credit[h] + CRED_BITS'(1);
         end
         if ((i_done & cred_full & ~take_vec) != '0) err_done <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_axi_val <= 1'b0;
         o_axi_dat <= '0;
         o_axi_ctl <= '0;
         o_axi_sop <= 1'b0;
         o_axi_eop <= 1'b0;
         o_axi_err <= 1'b0;
         o_axi_mod <= '0;
      end else if (fwd) begin
         o_axi_val <= 1'b1;
         o_axi_dat <= i_axi_dat;
         o_axi_ctl <= ctl_tag;
         o_axi_sop <= i_axi_sop;
         o_axi_eop <= i_axi_eop;
         o_axi_err <= i_axi_err;
         o_axi_mod <= i_axi_mod;
      end else if (o_axi_rdy) begin
         o_axi_val <= 1'b0;
      end
   end

   assign o_cred_ok = cred_nz;
   assign o_idle    = (state == IDLE) & ~o_axi_val & (&cred_full);
   assign o_err     = {err_sop, err_done};

endmodule

// File: tb/tb_tree_packet_arb_sched.sv
// Directed bench for tree_packet_arb_sched with 4 cores and 2 credits per core.
module tb_tree_packet_arb_sched;

   localparam int NO = 4;
   localparam int CR = 2;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_axi_val = 1'b0;
   logic        i_axi_rdy;
   logic [63:0] i_axi_dat = '0;
   logic [7:0]  i_axi_ctl = '0;
   logic        i_axi_sop = 1'b0;
   logic        i_axi_eop = 1'b0;
   logic        i_axi_err = 1'b0;
   logic [2:0]  i_axi_mod = '0;
   logic        o_axi_val;
   logic        o_axi_rdy = 1'b1;
   logic [63:0] o_axi_dat;
   logic [7:0]  o_axi_ctl;
   logic        o_axi_sop;
   logic        o_axi_eop;
   logic        o_axi_err;
   logic [2:0]  o_axi_mod;
   logic [3:0]  i_done = '0;
   logic [3:0]  o_cred_ok;
   logic        o_idle;
   logic [1:0]  o_err;

   int n_chk  = 0;
   int n_fail = 0;
   logic [73:0] capq [$];

   tree_packet_arb_sched #(
      .DAT_BYTS(8),
      .CTL_BITS(8),
      .NUM_OUT(NO),
      .CREDITS(CR)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_axi_val(i_axi_val), .i_axi_rdy(i_axi_rdy), .i_axi_dat(i_axi_dat),
      .i_axi_ctl(i_axi_ctl), .i_axi_sop(i_axi_sop), .i_axi_eop(i_axi_eop),
      .i_axi_err(i_axi_err), .i_axi_mod(i_axi_mod),
      .o_axi_val(o_axi_val), .o_axi_rdy(o_axi_rdy), .o_axi_dat(o_axi_dat),
      .o_axi_ctl(o_axi_ctl), .o_axi_sop(o_axi_sop), .o_axi_eop(o_axi_eop),
      .o_axi_err(o_axi_err), .o_axi_mod(o_axi_mod),
      .i_done(i_done), .o_cred_ok(o_cred_ok), .o_idle(o_idle), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk)
      if (o_axi_val && o_axi_rdy) capq.push_back({o_axi_sop, o_axi_eop, o_axi_ctl, o_axi_dat});

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Enter and leave at a falling edge; on return the accepted beat sits in the output register.
   task automatic push(input logic sop, input logic eop, input logic [63:0] dat, input logic [7:0] ctl);
      int n;
      i_axi_val = 1'b1;
      i_axi_sop = sop;
      i_axi_eop = eop;
      i_axi_dat = dat;
      i_axi_ctl = ctl;
      #1;
      n = 0;
      while (!i_axi_rdy && n < 10) begin
         @(negedge i_clk);
         #1;
         n++;
      end
      chk("push_rdy", i_axi_rdy, 1'b1);
      @(negedge i_clk);
      i_axi_val = 1'b0;
   endtask

   task automatic pulse(input logic [3:0] d);
      i_done = d;
      @(negedge i_clk);
      i_done = '0;
   endtask

   task automatic one(input string tag, input logic [1:0] id, input logic [63:0] dat);
      push(1'b1, 1'b1, dat, 8'hD5);
      chk({tag, "_val"}, o_axi_val, 1'b1);
      chk({tag, "_ctl"}, o_axi_ctl, {id, 6'h15});
      chk({tag, "_dat"}, o_axi_dat, dat);
   endtask

   initial begin
      logic [1:0]  ids [8];
      logic [73:0] ent;
      int b;
      logic acc;
      ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

      repeat (2) @(negedge i_clk);
      chk("rst_val", o_axi_val, 1'b0);
      chk("rst_idle", o_idle, 1'b1);
      chk("rst_cred", o_cred_ok, 4'b1111);
      chk("rst_err", o_err, 2'b00);
      i_rst = 1'b1;
      @(negedge i_clk);

      // round robin until every credit is gone
      for (int i = 0; i < 8; i++) one("rr", ids[i], 64'h100 + 64'(i));
      chk("exh_rdy", i_axi_rdy, 1'b0);
      chk("exh_cred", o_cred_ok, 4'b0000);
      chk("exh_idle", o_idle, 1'b0);
      @(negedge i_clk);
      chk("exh_val_drain", o_axi_val, 1'b0);

      // one returned credit on core 2
      pulse(4'b0100);
      chk("ret_rdy", i_axi_rdy, 1'b1);
      one("ret", 2'd2, 64'h200);
      chk("ret_cred", o_cred_ok, 4'b0000);

      pulse(4'b1111);
      pulse(4'b1111);
      chk("refill_idle", o_idle, 1'b1);
      chk("refill_err", o_err, 2'b00);

      // 3-beat packet through a toggling output ready
      capq.delete();
      b = 0;
      for (int c = 0; c < 30 && b < 3; c++) begin
         o_axi_rdy = (c % 2 == 0);
         i_axi_val = 1'b1;
         i_axi_sop = (b == 0);
         i_axi_eop = (b == 2);
         i_axi_dat = 64'hA0 + 64'(b);
         i_axi_ctl = 8'h3F;
         #1;
         acc = i_axi_rdy;
         @(negedge i_clk);
         if (acc) b++;
      end
      i_axi_val = 1'b0;
      for (int c = 0; c < 10 && capq.size() < 3; c++) begin
         o_axi_rdy = ~o_axi_rdy;
         @(negedge i_clk);
      end
      o_axi_rdy = 1'b1;
      @(negedge i_clk);
      chk("bp_count", capq.size(), 3);
      for (int i = 0; i < 3; i++) begin
         ent = (i < capq.size()) ? capq[i] : '1;
         chk("bp_beat", ent, {(i == 0), (i == 2), 2'd3, 6'h3F, 64'hA0 + 64'(i)});
      end

      // simultaneous take and return on core 1
      one("pre0", 2'd0, 64'h300);
      one("pre1", 2'd1, 64'h301);
      one("pre2", 2'd2, 64'h302);
      one("pre3", 2'd3, 64'h303);
      one("pre4", 2'd0, 64'h304);
      chk("pre_cred", o_cred_ok, 4'b0110);
      i_done = 4'b0010;
      i_axi_val = 1'b1;
      i_axi_sop = 1'b1;
      i_axi_eop = 1'b1;
      i_axi_dat = 64'h305;
      i_axi_ctl = 8'hD5;
      #1;
      chk("same_rdy", i_axi_rdy, 1'b1);
      @(negedge i_clk);
      i_done = '0;
      i_axi_val = 1'b0;
      chk("same_ctl", o_axi_ctl, {2'd1, 6'h15});
      chk("same_cred", o_cred_ok, 4'b0110);
      pulse(4'b1000);
      pulse(4'b1000);
      chk("full_err_pre", o_err, 2'b00);
      pulse(4'b1000);
      chk("full_err", o_err, 2'b01);
      pulse(4'b0001);
      pulse(4'b0001);
      pulse(4'b0110);
      chk("full_idle", o_idle, 1'b1);

      // non-sop beat while idle
      push(1'b0, 1'b1, 64'h400, 8'h00);
      chk("nosop_val", o_axi_val, 1'b0);
      chk("nosop_err", o_err, 2'b11);
      one("nosop_next", 2'd2, 64'h401);

      // reset in the middle of a 4-beat packet
      push(1'b1, 1'b0, 64'h500, 8'h01);
      chk("mid_b0", o_axi_ctl, {2'd3, 6'h01});
      push(1'b0, 1'b0, 64'h501, 8'h02);
      chk("mid_b1", o_axi_ctl, {2'd3, 6'h02});
      #2;
      i_rst = 1'b0;
      #1;
      chk("arst_val", o_axi_val, 1'b0);
      chk("arst_cred", o_cred_ok, 4'b1111);
      chk("arst_idle", o_idle, 1'b1);
      chk("arst_err", o_err, 2'b00);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      one("post0", 2'd0, 64'h600);
      one("post1", 2'd1, 64'h601);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
